// File: rtl/npu_out_collector.sv
// Neuron result collector: assembles MSB-first 4-byte words into a small register
// file, with frame status, error flags and an optional argmax tracker (NPU_OUT_ARGMAX_EN).
module npu_out_collector #(
  parameter int N_MAX  = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              CLKEXT,
  input  logic              RST,
  input  logic              EN_COL,
  input  logic [IDX_W-1:0]  NUM_NEURONS,
  input  logic              WR_EN,
  input  logic [7:0]        DIN,
  input  logic [IDX_W-1:0]  RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [IDX_W-1:0]  RES_CNT,
  output logic              DONE,
  output logic              BUSY,
  output logic [IDX_W-1:0]  CLASS_OUT,
  output logic              CLASS_VALID,
  output logic              ERR_FRAG,
  output logic              ERR_OVF
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic                r_done;
  logic                r_busy;
  logic [IDX_W-1:0]    r_n_exp;
  logic [IDX_W-1:0]    r_res_cnt;
  logic [1:0]          r_byte_cnt;
  logic [DATA_W-9:0]   r_hold;
  logic [DATA_W-1:0]   r_mem [N_MAX];
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_err_frag;
  logic                r_err_ovf;

  logic                w_start;
  logic                w_commit;
  logic                w_last;
  logic [IDX_W-1:0]    w_cnt_inc;
  logic [IDX_W-1:0]    w_n_clamp;
  logic [DATA_W-1:0]   w_word;

  // A new frame may only be opened from IDLE or DONE; EN_COL mid-frame is ignored.
  assign w_start   = EN_COL && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_commit  = (r_state == S_COLLECT) && WR_EN && (r_byte_cnt == 2'd3)
                     && (r_res_cnt < IDX_W'(N_MAX));
  assign w_word    = {r_hold, DIN};
  assign w_cnt_inc = r_res_cnt + IDX_W'(1);
  assign w_last    = (w_cnt_inc == r_n_exp);
  assign w_n_clamp = ((NUM_NEURONS == IDX_W'(0)) || (NUM_NEURONS > IDX_W'(N_MAX)))
                     ? IDX_W'(N_MAX) : NUM_NEURONS;

  // State register
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (EN_COL) w_state_nxt = S_COLLECT;
        else        w_state_nxt = S_IDLE;
      end
      S_COLLECT: begin
        if (w_commit && w_last) w_state_nxt = S_DONE;
        else                    w_state_nxt = S_COLLECT;
      end
      S_DONE: begin
        if (EN_COL) w_state_nxt = S_COLLECT;
        else        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they can be registered
  always_comb begin
    w_done_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    case (w_state_nxt)
      S_COLLECT: w_busy_nxt = 1'b1;
      S_DONE:    w_done_nxt = 1'b1;
      default: begin
        w_done_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Registered status flags
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Byte assembly, register file, read port and error flags
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_n_exp    <= IDX_W'(N_MAX);
      r_res_cnt  <= {IDX_W{1'b0}};
      r_byte_cnt <= 2'd0;
      r_hold     <= {(DATA_W-8){1'b0}};
      r_rd_data  <= {DATA_W{1'b0}};
      r_err_frag <= 1'b0;
      r_err_ovf  <= 1'b0;
      for (int i = 0; i < N_MAX; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      // Sees the pre-edge contents, so a same-edge commit reads back the old word.
      if (RD_ADDR < IDX_W'(N_MAX)) r_rd_data <= r_mem[RD_ADDR];
      else                         r_rd_data <= {DATA_W{1'b0}};

      if (w_start) begin
        r_n_exp    <= w_n_clamp;
        r_res_cnt  <= {IDX_W{1'b0}};
        r_byte_cnt <= 2'd0;
        r_err_frag <= 1'b0;
        r_err_ovf  <= 1'b0;
      end else if (r_state == S_COLLECT) begin
        if (WR_EN) begin
          if (r_byte_cnt == 2'd3) begin
            if (w_commit) begin
              r_mem[r_res_cnt] <= w_word;
              r_res_cnt        <= w_cnt_inc;
            end
            r_byte_cnt <= 2'd0;
          end else begin
            r_hold     <= {r_hold[DATA_W-17:0], DIN};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end else if (r_byte_cnt != 2'd0) begin
          r_err_frag <= 1'b1;
          r_byte_cnt <= 2'd0;
        end
      end else if ((r_state == S_DONE) && WR_EN) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

`ifdef NPU_OUT_ARGMAX_EN
  logic [DATA_W-1:0] r_max;
  logic [IDX_W-1:0]  r_class;

  // Running argmax: strict compare keeps the lower index on ties
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      r_max   <= {DATA_W{1'b0}};
      r_class <= {IDX_W{1'b0}};
    end else if (w_start) begin
      r_max   <= {DATA_W{1'b0}};
      r_class <= {IDX_W{1'b0}};
    end else if (w_commit && ((r_res_cnt == IDX_W'(0)) || (w_word > r_max))) begin
      r_max   <= w_word;
      r_class <= r_res_cnt;
    end
  end

  assign CLASS_OUT   = r_class;
  assign CLASS_VALID = r_done;
`else
  assign CLASS_OUT   = {IDX_W{1'b0}};
  assign CLASS_VALID = 1'b0;
`endif

  assign RD_DATA  = r_rd_data;
  assign RES_CNT  = r_res_cnt;
  assign DONE     = r_done;
  assign BUSY     = r_busy;
  assign ERR_FRAG = r_err_frag;
  assign ERR_OVF  = r_err_ovf;

endmodule

// File: tb/tb_npu_out_collector.sv
// Scoreboard bench for npu_out_collector: stimulus queues expected status/read
// values; a monitor pops them one cycle later and compares.
module tb_npu_out_collector;

  logic        CLKEXT;
  logic        RST;
  logic        EN_COL;
  logic [3:0]  NUM_NEURONS;
  logic        WR_EN;
  logic [7:0]  DIN;
  logic [3:0]  RD_ADDR;
  logic [31:0] RD_DATA;
  logic [3:0]  RES_CNT;
  logic        DONE;
  logic        BUSY;
  logic [3:0]  CLASS_OUT;
  logic        CLASS_VALID;
  logic        ERR_FRAG;
  logic        ERR_OVF;

  npu_out_collector dut (
    .CLKEXT(CLKEXT), .RST(RST), .EN_COL(EN_COL), .NUM_NEURONS(NUM_NEURONS),
    .WR_EN(WR_EN), .DIN(DIN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .RES_CNT(RES_CNT), .DONE(DONE), .BUSY(BUSY), .CLASS_OUT(CLASS_OUT),
    .CLASS_VALID(CLASS_VALID), .ERR_FRAG(ERR_FRAG), .ERR_OVF(ERR_OVF)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [3:0]  cnt;
    logic        done;
    logic        busy;
    logic        frag;
    logic        ovf;
    logic [3:0]  cls;
    logic        clsv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  req;
  int    checks = 0;
  int    errors = 0;

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, expv);
    end
  endtask

  task automatic tick;
    @(negedge CLKEXT);
    WR_EN  = 1'b0;
    EN_COL = 1'b0;
    req    = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    WR_EN = 1'b1;
    DIN   = b;
  endtask

  task automatic send_bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      put(w[31-8*i -: 8]);
      tick();
    end
  endtask

  // Expected values describe the outputs just after the next rising edge.
  task automatic push_exp(input string nm, input logic [3:0] addr, input logic [31:0] rd,
                          input logic [3:0] cnt, input logic done, input logic busy,
                          input logic frag, input logic ovf, input logic [3:0] cls);
    exp_t e;
    RD_ADDR = addr;
    e.rd    = rd;
    e.cnt   = cnt;
    e.done  = done;
    e.busy  = busy;
    e.frag  = frag;
    e.ovf   = ovf;
`ifdef NPU_OUT_ARGMAX_EN
    e.cls   = cls;
    e.clsv  = done;
`else
    e.cls   = 4'd0;
    e.clsv  = 1'b0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    req = 1'b1;
  endtask

  // Monitor: pops one expectation per requested cycle, samples 1 time unit after the edge
  initial begin
    logic  fire;
    exp_t  e;
    string nm;
    forever begin
      @(posedge CLKEXT);
      fire = req;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard got empty queue expected an entry");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          cmp(nm, "rd_data", RD_DATA, e.rd);
          cmp(nm, "res_cnt", {28'd0, RES_CNT}, {28'd0, e.cnt});
          cmp(nm, "done", {31'd0, DONE}, {31'd0, e.done});
          cmp(nm, "busy", {31'd0, BUSY}, {31'd0, e.busy});
          cmp(nm, "err_frag", {31'd0, ERR_FRAG}, {31'd0, e.frag});
          cmp(nm, "err_ovf", {31'd0, ERR_OVF}, {31'd0, e.ovf});
          cmp(nm, "class_out", {28'd0, CLASS_OUT}, {28'd0, e.cls});
          cmp(nm, "class_valid", {31'd0, CLASS_VALID}, {31'd0, e.clsv});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; EN_COL = 1'b0; NUM_NEURONS = 4'd0; WR_EN = 1'b0;
    DIN = 8'd0; RD_ADDR = 4'd0; req = 1'b0;
    tick(); tick();
    RST = 1'b0;

    // Reset state, every read address returns zero
    for (int a = 0; a < 16; a++) begin
      push_exp("reset", 4'(a), 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
    end

    // Nominal frame of 3
    EN_COL = 1'b1; NUM_NEURONS = 4'd3;
    push_exp("start1", 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); tick();
    send_bytes(32'h0000_0010, 4);
    send_bytes(32'h0000_0200, 4);
    push_exp("mid1", 4'd1, 32'h0000_0200, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1); tick();
    send_bytes(32'h0000_0050, 3);
    put(8'h50);
    push_exp("last1_oldread", 4'd2, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    push_exp("rd1_0", 4'd0, 32'h0000_0010, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    push_exp("rd1_1", 4'd1, 32'h0000_0200, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    push_exp("rd1_2", 4'd2, 32'h0000_0050, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    push_exp("rd1_10", 4'd10, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();
    push_exp("rd1_15", 4'd15, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1); tick();

    // Overflow in DONE writes nothing
    put(8'hAA);
    push_exp("ovf", 4'd3, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1); tick();
    push_exp("ovf_mem", 4'd2, 32'h0000_0050, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1); tick();

    // Restart with NUM_NEURONS=0 (expects 10), fragment then full word
    EN_COL = 1'b1; NUM_NEURONS = 4'd0;
    push_exp("restart", 4'd0, 32'h0000_0010, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); tick();
    send_bytes(32'h1234_0000, 2);
    push_exp("frag", 4'd0, 32'h0000_0010, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0); tick();
    send_bytes(32'hDEAD_BEEF, 3);
    put(8'hEF);
    push_exp("frag_word", 4'd0, 32'h0000_0010, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0); tick();
    push_exp("frag_rd", 4'd0, 32'hDEAD_BEEF, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0); tick();
    for (int i = 1; i < 9; i++) send_bytes(32'd0, 4);
    EN_COL = 1'b1;
    push_exp("encol_ignored", 4'd9, 32'd0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0); tick();
    send_bytes(32'h0000_0001, 3);
    put(8'h01);
    push_exp("n0_done", 4'd9, 32'd0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); tick();
    push_exp("n0_rd9", 4'd9, 32'h0000_0001, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0); tick();

    // Tie frame: idx4 and idx7 equal maxima
    EN_COL = 1'b1; NUM_NEURONS = 4'd10;
    push_exp("tie_start", 4'd0, 32'hDEAD_BEEF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); tick();
    for (int i = 0; i < 9; i++) send_bytes(((i == 4) || (i == 7)) ? 32'h7F : 32'd0, 4);
    send_bytes(32'd0, 3);
    put(8'h00);
    push_exp("tie_done", 4'd7, 32'h0000_007F, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4); tick();
    push_exp("tie_rd0", 4'd0, 32'd0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4); tick();

    // Reset after 6 bytes of a frame
    EN_COL = 1'b1; NUM_NEURONS = 4'd2;
    push_exp("rm_start", 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); tick();
    send_bytes(32'h1122_3344, 4);
    send_bytes(32'h5566_7788, 2);
    RST = 1'b1;
    push_exp("rm_reset", 4'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    RST = 1'b0;
    put(8'h55);
    push_exp("idle_wr", 4'd1, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    EN_COL = 1'b1; NUM_NEURONS = 4'd1;
    push_exp("rm_new", 4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); tick();
    send_bytes(32'hCAFE_F00D, 3);
    put(8'h0D);
    push_exp("rm_commit", 4'd0, 32'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); tick();
    push_exp("rm_rd", 4'd0, 32'hCAFE_F00D, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); tick();

    tick(); tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
